fetch_unit: RTL and testbench

Instruction-fetch stage for the ARM-subset processor. Holds the program counter, drives the word address into the instruction memory, and registers the returned instruction word together with its PC for the decode stage. Handles stall, taken-branch redirect, and sticky fetch faults for misaligned or out-of-range addresses. Sits directly upstream of the instruction memory and between it and decode.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register for decode,
// branch redirect with a single bubble, and a sticky fault for bad fetch addresses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // state  | meaning
  // BOOT   | out of reset, PC = RESET_PC, first fetch on next edge
  // RUN    | normal fetch, honours branch redirect and stall
  // FAULT  | bad fetch address seen, frozen until reset
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // One extra bit so MEM_WORDS = 2^30 still compares correctly.
  localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        pc_in_range;
  logic        target_ok;

  assign pc_in_range = ({1'b0, pc_q[31:2]} < MEM_LIMIT);
  assign target_ok   = (branch_target[1:0] == 2'b00) &&
                       ({1'b0, branch_target[31:2]} < MEM_LIMIT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_BOOT: begin
        if (pc_in_range) begin
          instr_d       = imem_rd;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_RUN;
        end else begin
          instr_valid_d = 1'b0;
          fault_d       = 1'b1;
          state_d       = ST_FAULT;
        end
      end

      ST_RUN: begin
        if (branch_taken) begin
          // PC takes the target either way so a fault leaves the offending address visible.
          pc_d          = branch_target;
          instr_valid_d = 1'b0;
          if (!target_ok) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (!pc_in_range) begin
          instr_valid_d = 1'b0;
          fault_d       = 1'b1;
          state_d       = ST_FAULT;
        end else begin
          instr_d       = imem_rd;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end

      ST_FAULT: begin
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
      end

      default: begin
        instr_valid_d = 1'b0;
        fault_d       = 1'b1;
        state_d       = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_pc8   = instr_pc_q + 32'd8;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 101-word instance for run/stall/branch/reset
// and a 4-word instance for sequential out-of-range faulting.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        reset_s;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] imem_addr, imem_rd, instr, instr_pc, instr_pc8, fetch_count;
  logic        instr_valid, fault;

  logic [31:0] imem_addr_s, imem_rd_s, instr_s, instr_pc_s, instr_pc8_s, fetch_count_s;
  logic        instr_valid_s, fault_s;

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    case (idx)
      30'd0:   word_at = 32'hE3A0_0078;
      30'd1:   word_at = 32'hE3A0_1E4B;
      default: word_at = 32'hE280_0000 | {2'b00, idx};
    endcase
  endfunction

  assign imem_rd   = word_at(imem_addr);
  assign imem_rd_s = word_at(imem_addr_s);

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(101)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
    .instr_valid(instr_valid), .fault(fault), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut_s (
    .clk(clk), .reset(reset_s), .imem_addr(imem_addr_s), .imem_rd(imem_rd_s),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .instr(instr_s), .instr_pc(instr_pc_s), .instr_pc8(instr_pc8_s),
    .instr_valid(instr_valid_s), .fault(fault_s), .fetch_count(fetch_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr got %h exp %h", imem_addr, 32'h0); end
    vec_cnt++; if (instr !== 32'h0) begin err_cnt++; $display("FAIL rst_instr got %h exp %h", instr, 32'h0); end
    vec_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got %h exp %h", instr_pc, 32'h0); end
    vec_cnt++; if (instr_pc8 !== 32'h8) begin err_cnt++; $display("FAIL rst_pc8 got %h exp %h", instr_pc8, 32'h8); end
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("FAIL rst_fault got %b exp 0", fault); end
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL rst_count got %h exp 0", fetch_count); end
    #1 reset = 1'b1;
  endtask

  task automatic test_free_run();
    edge_sample();
    vec_cnt++; if (instr !== 32'hE3A00078) begin err_cnt++; $display("FAIL run1_instr got %h exp %h", instr, 32'hE3A00078); end
    vec_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL run1_pc got %h exp 0", instr_pc); end
    vec_cnt++; if (instr_pc8 !== 32'h8) begin err_cnt++; $display("FAIL run1_pc8 got %h exp 8", instr_pc8); end
    vec_cnt++; if (instr_valid !== 1'b1) begin err_cnt++; $display("FAIL run1_valid got %b exp 1", instr_valid); end
    vec_cnt++; if (fetch_count !== 32'd1) begin err_cnt++; $display("FAIL run1_count got %0d exp 1", fetch_count); end
    edge_sample();
    vec_cnt++; if (instr !== 32'hE3A01E4B) begin err_cnt++; $display("FAIL run2_instr got %h exp %h", instr, 32'hE3A01E4B); end
    vec_cnt++; if (instr_pc !== 32'h4) begin err_cnt++; $display("FAIL run2_pc got %h exp 4", instr_pc); end
    vec_cnt++; if (fetch_count !== 32'd2) begin err_cnt++; $display("FAIL run2_count got %0d exp 2", fetch_count); end
    edge_sample();
    edge_sample();
    vec_cnt++; if (instr_pc !== 32'hC) begin err_cnt++; $display("FAIL run4_pc got %h exp c", instr_pc); end
    vec_cnt++; if (instr !== 32'hE2800003) begin err_cnt++; $display("FAIL run4_instr got %h exp e2800003", instr); end
    vec_cnt++; if (imem_addr !== 32'h10) begin err_cnt++; $display("FAIL run4_addr got %h exp 10", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      vec_cnt++; if (imem_addr !== 32'h10) begin err_cnt++; $display("FAIL stall%0d_addr got %h exp 10", i, imem_addr); end
      vec_cnt++; if (instr_pc !== 32'hC) begin err_cnt++; $display("FAIL stall%0d_pc got %h exp c", i, instr_pc); end
      vec_cnt++; if (instr !== 32'hE2800003) begin err_cnt++; $display("FAIL stall%0d_instr got %h exp e2800003", i, instr); end
      vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL stall%0d_count got %0d exp 4", i, fetch_count); end
      vec_cnt++; if (instr_valid !== 1'b1) begin err_cnt++; $display("FAIL stall%0d_valid got %b exp 1", i, instr_valid); end
    end
    stall = 1'b0;
    edge_sample();
    vec_cnt++; if (instr_pc !== 32'h10) begin err_cnt++; $display("FAIL resume_pc got %h exp 10", instr_pc); end
    vec_cnt++; if (instr !== 32'hE2800004) begin err_cnt++; $display("FAIL resume_instr got %h exp e2800004", instr); end
    vec_cnt++; if (fetch_count !== 32'd5) begin err_cnt++; $display("FAIL resume_count got %0d exp 5", fetch_count); end
  endtask

  task automatic test_branch(input logic with_stall, input logic [31:0] exp_count);
    branch_taken  = 1'b1;
    branch_target = 32'h78;
    stall         = with_stall;
    edge_sample();
    branch_taken = 1'b0;
    stall        = 1'b0;
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL br%0b_bubble got %b exp 0", with_stall, instr_valid); end
    vec_cnt++; if (imem_addr !== 32'h78) begin err_cnt++; $display("FAIL br%0b_addr got %h exp 78", with_stall, imem_addr); end
    vec_cnt++; if (fetch_count !== exp_count) begin err_cnt++; $display("FAIL br%0b_count_hold got %0d exp %0d", with_stall, fetch_count, exp_count); end
    vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("FAIL br%0b_fault got %b exp 0", with_stall, fault); end
    edge_sample();
    vec_cnt++; if (instr_pc !== 32'h78) begin err_cnt++; $display("FAIL br%0b_tgt_pc got %h exp 78", with_stall, instr_pc); end
    vec_cnt++; if (instr_valid !== 1'b1) begin err_cnt++; $display("FAIL br%0b_tgt_valid got %b exp 1", with_stall, instr_valid); end
    vec_cnt++; if (instr !== 32'hE280001E) begin err_cnt++; $display("FAIL br%0b_tgt_instr got %h exp e280001e", with_stall, instr); end
    vec_cnt++; if (instr_pc8 !== 32'h80) begin err_cnt++; $display("FAIL br%0b_tgt_pc8 got %h exp 80", with_stall, instr_pc8); end
    vec_cnt++; if (fetch_count !== exp_count + 32'd1) begin err_cnt++; $display("FAIL br%0b_tgt_count got %0d exp %0d", with_stall, fetch_count, exp_count + 32'd1); end
  endtask

  task automatic test_reset_mid();
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    edge_sample();
    branch_taken = 1'b0;
    vec_cnt++; if (imem_addr !== 32'h20) begin err_cnt++; $display("FAIL mid_setup_addr got %h exp 20", imem_addr); end
    #3 reset = 1'b0;
    #1;
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_addr got %h exp 0", imem_addr); end
    vec_cnt++; if (instr !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_instr got %h exp 0", instr); end
    vec_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_pc got %h exp 0", instr_pc); end
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_count got %0d exp 0", fetch_count); end
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid got %b exp 0", instr_valid); end
    #2 reset = 1'b1;
    edge_sample();
    vec_cnt++; if (instr !== 32'hE3A00078) begin err_cnt++; $display("FAIL mid_first_instr got %h exp e3a00078", instr); end
    vec_cnt++; if (instr_pc !== 32'h0) begin err_cnt++; $display("FAIL mid_first_pc got %h exp 0", instr_pc); end
    vec_cnt++; if (fetch_count !== 32'd1) begin err_cnt++; $display("FAIL mid_first_count got %0d exp 1", fetch_count); end
  endtask

  task automatic test_misaligned();
    branch_taken  = 1'b1;
    branch_target = 32'h7A;
    edge_sample();
    vec_cnt++; if (fault !== 1'b1) begin err_cnt++; $display("FAIL mis_fault got %b exp 1", fault); end
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL mis_valid got %b exp 0", instr_valid); end
    vec_cnt++; if (imem_addr !== 32'h7A) begin err_cnt++; $display("FAIL mis_addr got %h exp 7a", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      stall         = i[0];
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      edge_sample();
      vec_cnt++; if (fault !== 1'b1) begin err_cnt++; $display("FAIL mis_sticky%0d_fault got %b exp 1", i, fault); end
      vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL mis_sticky%0d_valid got %b exp 0", i, instr_valid); end
      vec_cnt++; if (imem_addr !== 32'h7A) begin err_cnt++; $display("FAIL mis_sticky%0d_addr got %h exp 7a", i, imem_addr); end
      vec_cnt++; if (fetch_count !== 32'd1) begin err_cnt++; $display("FAIL mis_sticky%0d_count got %0d exp 1", i, fetch_count); end
    end
    stall        = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_branch_range();
    reset = 1'b0;
    #2 reset = 1'b1;
    edge_sample();
    branch_taken  = 1'b1;
    branch_target = 32'h190;
    edge_sample();
    branch_taken = 1'b0;
    vec_cnt++; if (fault !== 1'b0) begin err_cnt++; $display("FAIL last_word_fault got %b exp 0", fault); end
    vec_cnt++; if (imem_addr !== 32'h190) begin err_cnt++; $display("FAIL last_word_addr got %h exp 190", imem_addr); end
    edge_sample();
    vec_cnt++; if (instr_pc !== 32'h190) begin err_cnt++; $display("FAIL last_word_pc got %h exp 190", instr_pc); end
    vec_cnt++; if (instr_valid !== 1'b1) begin err_cnt++; $display("FAIL last_word_valid got %b exp 1", instr_valid); end
    edge_sample();
    vec_cnt++; if (fault !== 1'b1) begin err_cnt++; $display("FAIL past_end_fault got %b exp 1", fault); end
    vec_cnt++; if (instr_valid !== 1'b0) begin err_cnt++; $display("FAIL past_end_valid got %b exp 0", instr_valid); end
    vec_cnt++; if (imem_addr !== 32'h194) begin err_cnt++; $display("FAIL past_end_addr got %h exp 194", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'd2) begin err_cnt++; $display("FAIL past_end_count got %0d exp 2", fetch_count); end
  endtask

  task automatic test_out_of_range();
    reset_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_sample();
      vec_cnt++; if (instr_pc_s !== 32'(i * 4)) begin err_cnt++; $display("FAIL oor_w%0d_pc got %h exp %h", i, instr_pc_s, 32'(i * 4)); end
      vec_cnt++; if (instr_s !== word_at(32'(i * 4))) begin err_cnt++; $display("FAIL oor_w%0d_instr got %h exp %h", i, instr_s, word_at(32'(i * 4))); end
      vec_cnt++; if (instr_valid_s !== 1'b1) begin err_cnt++; $display("FAIL oor_w%0d_valid got %b exp 1", i, instr_valid_s); end
      vec_cnt++; if (fault_s !== 1'b0) begin err_cnt++; $display("FAIL oor_w%0d_fault got %b exp 0", i, fault_s); end
    end
    edge_sample();
    vec_cnt++; if (fault_s !== 1'b1) begin err_cnt++; $display("FAIL oor_fault got %b exp 1", fault_s); end
    vec_cnt++; if (instr_valid_s !== 1'b0) begin err_cnt++; $display("FAIL oor_valid got %b exp 0", instr_valid_s); end
    vec_cnt++; if (fetch_count_s !== 32'd4) begin err_cnt++; $display("FAIL oor_count got %0d exp 4", fetch_count_s); end
    vec_cnt++; if (imem_addr_s !== 32'h10) begin err_cnt++; $display("FAIL oor_addr got %h exp 10", imem_addr_s); end
    edge_sample();
    vec_cnt++; if (fault_s !== 1'b1) begin err_cnt++; $display("FAIL oor_sticky got %b exp 1", fault_s); end
  endtask

  initial begin
    reset         = 1'b0;
    reset_s       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch(1'b0, 32'd5);
    test_branch(1'b1, 32'd6);
    test_reset_mid();
    test_misaligned();
    test_branch_range();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
